// File: rtl/xrv_mul.sv
`default_nettype none
// ============================================================================
//  Module      : xrv_mul
//  Description : Iterative shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU.
//                Operands are reduced to magnitudes, multiplied unsigned at
//                BITS_PER_CYCLE multiplier bits per cycle, and the 64-bit
//                product is negated at the end when the signs differ.
//                One-cycle launch pulse, fixed latency of K+1 cycles,
//                one-cycle result_valid pulse, result held afterwards.
//  Revision    : 1.0  initial release
// ============================================================================
module xrv_mul #(
    parameter int BITS_PER_CYCLE = 1          // legal values: 1, 2, 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] multiplicand,
    input  logic [31:0] multiplier,
    input  logic [1:0]  optype,
    input  logic        valid,
    output logic        busy,
    output logic [31:0] result,
    output logic        result_valid
);

    localparam int B     = BITS_PER_CYCLE;
    localparam int K     = 32 / B;
    localparam int CNT_W = (K > 1) ? $clog2(K) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(K - 1);

    localparam logic [1:0] C_OP_MUL    = 2'b00;
    localparam logic [1:0] C_OP_MULH   = 2'b01;
    localparam logic [1:0] C_OP_MULHSU = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [63:0]      r_acc;
    logic [31:0]      r_mcand;
    logic [31:0]      r_mplier;
    logic             r_neg;
    logic [1:0]       r_op;

    logic             w_s1;
    logic             w_s2;
    logic [31:0]      w_mag1;
    logic [31:0]      w_mag2;
    logic [B-1:0]     w_digit;
    logic [31+B:0]    w_pp;
    logic [31+B:0]    w_sum;
    logic [63:0]      w_acc_nxt;
    logic [63:0]      w_prod;
    logic [31:0]      w_res;

    // Operand sign detection and magnitude conversion at launch.
    // MUL treats both operands as unsigned since the low word does not depend
    // on signedness; |0x80000000| stays 0x80000000 as an unsigned magnitude.
    always_comb begin
        w_s1   = ((optype == C_OP_MULH) || (optype == C_OP_MULHSU)) & multiplicand[31];
        w_s2   = (optype == C_OP_MULH) & multiplier[31];
        w_mag1 = w_s1 ? (~multiplicand + 32'd1) : multiplicand;
        w_mag2 = w_s2 ? (~multiplier   + 32'd1) : multiplier;
    end

    // One iteration: add mcand * digit into the upper half and shift the
    // whole accumulator right by B. hi < 2^32 and pp <= (2^32-1)(2^B-1), so
    // the sum is strictly below 2^(32+B) and 32+B bits hold it without loss.
    always_comb begin
        w_digit   = r_mplier[B-1:0];
        w_pp      = {{B{1'b0}}, r_mcand} * {32'd0, w_digit};
        w_sum     = {{B{1'b0}}, r_acc[63:32]} + w_pp;
        w_acc_nxt = {w_sum, r_acc[31:B]};
        w_prod    = r_neg ? (~w_acc_nxt + 64'd1) : w_acc_nxt;
        w_res     = (r_op == C_OP_MUL) ? w_prod[31:0] : w_prod[63:32];
    end

    // Control FSM and datapath registers; a new launch always wins over an
    // op in flight or completing on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_acc        <= '0;
            r_mcand      <= '0;
            r_mplier     <= '0;
            r_neg        <= 1'b0;
            r_op         <= '0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            result       <= '0;
        end else if (valid) begin
            r_state      <= S_RUN;
            r_cnt        <= '0;
            r_acc        <= '0;
            r_mcand      <= w_mag1;
            r_mplier     <= w_mag2;
            r_neg        <= w_s1 ^ w_s2;
            r_op         <= optype;
            busy         <= 1'b1;
            result_valid <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    r_acc    <= w_acc_nxt;
                    r_mplier <= r_mplier >> B;
                    if (r_cnt == C_LAST) begin
                        r_cnt        <= '0;
                        r_state      <= S_DONE;
                        busy         <= 1'b0;
                        result_valid <= 1'b1;
                        result       <= w_res;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state      <= S_IDLE;
                    result_valid <= 1'b0;
                end
                default: begin
                    r_state      <= S_IDLE;
                    busy         <= 1'b0;
                    result_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
